fetch_unit_r32i: RTL
====================

Name: fetch_unit_r32i

Overview:
Instruction fetch front end that produces the raw 32-bit instruction word consumed by the RV32I decoder.
- Holds the program counter and issues in-order read requests to instruction memory.
- Buffers returned words with their PCs in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Takes PC redirects from the branch/jump resolution logic (JAL, JALR, taken conditional branches) and discards wrong-path words.

Parameters:
dataW, 32, instruction and address width.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BUF_DEPTH, 2, instruction buffer entries; also the maximum number of requests in flight plus buffered words (power of 2, >=2).

Ports:
clk  input  1  clock, all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_addr  output  dataW  word-aligned fetch address, equal to the current PC.
imem_rsp_valid  input  1  read data valid; responses arrive in order, at least 1 cycle after acceptance, and cannot be stalled.
imem_rsp_data  input  dataW  returned instruction word.
redirect_valid  input  1  one-cycle pulse that redirects the PC.
redirect_target  input  dataW  new PC; bits [1:0] are ignored and forced to 0.
ins_valid  output  1  rawIns and ins_pc are valid.
ins_ready  input  1  decoder consumes the head entry.
rawIns  output  dataW  instruction word at the buffer head.
ins_pc  output  dataW  address of rawIns.

Behaviour:
- Reset, asynchronous on rst rising; all values hold while rst is high:
  - pc = RESET_PC; buffer empty; outstanding = 0; drop = 0.
  - imem_req_valid = 0, ins_valid = 0, rawIns = 0, ins_pc = 0.
  - imem_addr = RESET_PC.
- Credit rule: imem_req_valid = (outstanding + occupancy < BUF_DEPTH) and not redirect_valid.
  - outstanding includes requests whose responses will be dropped.
- Request handshake (imem_req_valid and imem_req_ready):
  - outstanding increments; pc += 4, wrapping modulo 2^dataW.
  - The PC of each in-flight request is held in an address queue of depth BUF_DEPTH.
- Response:
  - outstanding decrements and the address queue pops.
  - If drop > 0, the word is discarded and drop decrements.
  - Otherwise {imem_rsp_data, popped PC} is pushed into the buffer.
  - The credit rule guarantees the buffer is never full on a push. A response with outstanding = 0 is a protocol violation; the block ignores it.
- Output: ins_valid = buffer not empty; rawIns/ins_pc come from registered head storage. A pop occurs on ins_valid and ins_ready.
- Minimum latency: request accepted in cycle N, response in N+1, ins_valid in N+2.
- Simultaneous push and pop on a non-empty buffer keeps occupancy unchanged.
- Redirect (redirect_valid in cycle N):
  - Buffer flushed; ins_valid = 0 in N+1.
  - pc = {redirect_target[dataW-1:2], 2'b00} in N+1.
  - drop = outstanding after this cycle's updates, i.e. responses arriving in cycle N are dropped directly and are not counted into drop.
  - imem_req_valid is 0 in cycle N. No request is issued to the old PC, and the pc += 4 is suppressed.
  - Earliest request to the target is N+1, subject to credit. Stale in-flight requests still consume credit until their responses arrive.
  - An ins handshake in cycle N is legal; the consumed word is still taken by the decoder, and the rest of the buffer is flushed.
  - Back-to-back redirects: the last one wins; drop accumulates correctly.
- State machine:
  - RUN: normal operation.
  - FLUSH: drop > 0. Requests are still allowed, and the output buffer only receives non-dropped words.
  - FLUSH to RUN when drop reaches 0.
  - Reset mid-operation returns to RUN with all counters cleared; memory responses to pre-reset requests must not arrive after reset (system guarantee).

Test Plan:
- Reset then stream: rst 1→0, imem_req_ready=1, memory returns 0x00000013 one cycle after each request, ins_ready=1 → ins_pc sequence 0x0,0x4,0x8,…, first ins_valid 2 cycles after first accept, no gaps.
- Backpressure: ins_ready=0 for 10 cycles → exactly BUF_DEPTH (2) requests accepted, then imem_req_valid=0; ins_ready=1 → words popped in order 0x0,0x4 with no loss or duplicate.
- Redirect with in-flight: 2 outstanding requests (0x8,0xC), redirect_valid with target 0x103 → both responses dropped, next imem_addr=0x100, first delivered ins_pc=0x100.
- Redirect coincident with response and request-ready: rsp_valid, redirect_valid and imem_req_ready all 1 in cycle N, target 0x40 → that response not delivered, no request issued in N, imem_addr=0x40 at N+1.
- PC wrap: RESET_PC=0xFFFFFFF8 → ins_pc 0xFFFFFFF8,0xFFFFFFFC,0x00000000.
- Async reset mid-stream: assert rst between edges with a full buffer → ins_valid and imem_req_valid fall immediately, and after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_r32i_if.sv
// Fetch front-end bus bundle: instruction-memory request/response, PC redirect
// and the decoder-facing instruction handshake.
interface fetch_unit_r32i_if #(
  parameter int unsigned dataW = 32
) ();
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [dataW-1:0] imem_addr;
  logic             imem_rsp_valid;
  logic [dataW-1:0] imem_rsp_data;
  logic             redirect_valid;
  logic [dataW-1:0] redirect_target;
  logic             ins_valid;
  logic             ins_ready;
  logic [dataW-1:0] rawIns;
  logic [dataW-1:0] ins_pc;

  modport master (
    output imem_req_valid, imem_addr, ins_valid, rawIns, ins_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_target, ins_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, ins_valid, rawIns, ins_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_target, ins_ready
  );
endinterface

// File: rtl/fetch_unit_r32i.sv
// RV32I fetch front end: PC generation, credit-limited in-order memory requests,
// instruction buffer toward the decoder, and redirect with wrong-path discard.
module fetch_unit_r32i #(
  parameter int unsigned      dataW     = 32,
  parameter logic [dataW-1:0] RESET_PC  = dataW'(0),
  parameter int unsigned      BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_r32i_if.master  bus
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [dataW-1:0] word;
    logic [dataW-1:0] pc;
  } ins_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_e;

  state_e             state_q, state_d;
  logic [dataW-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  ins_entry_t         buf_q [BUF_DEPTH];
  ins_entry_t         buf_d [BUF_DEPTH];
  logic [PTR_W-1:0]   buf_rd_q, buf_rd_d;
  logic [PTR_W-1:0]   buf_wr_q, buf_wr_d;
  logic [dataW-1:0]   aq_q [BUF_DEPTH];
  logic [dataW-1:0]   aq_d [BUF_DEPTH];
  logic [PTR_W-1:0]   aq_rd_q, aq_rd_d;
  logic [PTR_W-1:0]   aq_wr_q, aq_wr_d;
  ins_entry_t         head_q, head_d;

  logic [CNT_W:0]     inflight_c;
  logic               req_valid_c;
  logic               req_fire_c;
  logic               rsp_take_c;
  logic               rsp_keep_c;
  logic               ins_fire_c;

  // Credit covers both buffered words and every in-flight request, stale or not.
  assign inflight_c  = {1'b0, outstanding_q} + {1'b0, occ_q};
  assign req_valid_c = !rst && (inflight_c < (CNT_W + 1)'(BUF_DEPTH)) && !bus.redirect_valid;
  assign req_fire_c  = req_valid_c && bus.imem_req_ready;
  assign rsp_take_c  = bus.imem_rsp_valid && (outstanding_q != '0);
  assign rsp_keep_c  = rsp_take_c && (state_q == ST_RUN) && !bus.redirect_valid;
  assign ins_fire_c  = (occ_q != '0) && bus.ins_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      occ_q         <= '0;
      buf_rd_q      <= '0;
      buf_wr_q      <= '0;
      aq_rd_q       <= '0;
      aq_wr_q       <= '0;
      head_q        <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
        aq_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      occ_q         <= occ_d;
      buf_rd_q      <= buf_rd_d;
      buf_wr_q      <= buf_wr_d;
      aq_rd_q       <= aq_rd_d;
      aq_wr_q       <= aq_wr_d;
      head_q        <= head_d;
      buf_q         <= buf_d;
      aq_q          <= aq_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    occ_d         = occ_q;
    buf_d         = buf_q;
    buf_rd_d      = buf_rd_q;
    buf_wr_d      = buf_wr_q;
    aq_d          = aq_q;
    aq_rd_d       = aq_rd_q;
    aq_wr_d       = aq_wr_q;

    if (req_fire_c) begin
      aq_d[aq_wr_q] = pc_q;
      aq_wr_d       = aq_wr_q + PTR_W'(1);
      pc_d          = pc_q + dataW'(4);
    end

    if (rsp_take_c) begin
      aq_rd_d = aq_rd_q + PTR_W'(1);
    end

    case ({req_fire_c, rsp_take_c})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: ;
    endcase

    if (rsp_take_c && (state_q == ST_FLUSH)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    if (rsp_keep_c) begin
      buf_d[buf_wr_q] = '{word: bus.imem_rsp_data, pc: aq_q[aq_rd_q]};
      buf_wr_d        = buf_wr_q + PTR_W'(1);
    end

    if (ins_fire_c) begin
      buf_rd_d = buf_rd_q + PTR_W'(1);
    end

    case ({rsp_keep_c, ins_fire_c})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: ;
    endcase

    // Redirect wins: every response still owed belongs to the old path.
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_target & ~dataW'(3);
      buf_rd_d = buf_wr_q;
      buf_wr_d = buf_wr_q;
      occ_d    = '0;
      drop_d   = outstanding_d;
    end

    state_d = (drop_d != '0) ? ST_FLUSH : ST_RUN;
    head_d  = buf_d[buf_rd_d];
  end

  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_addr      = pc_q;
  assign bus.ins_valid      = (occ_q != '0);
  assign bus.rawIns         = head_q.word;
  assign bus.ins_pc         = head_q.pc;

endmodule
